// File: rtl/dispatch1_8.sv
// Two-entry FIFO that routes each stored payload to one of eight consumer channels
// over a shared data bus, delivering strictly in push order.
module dispatch1_8 #(
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [DATA_W-1:0] in_data,
   input  logic [2:0]        in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [7:0]        out_valid,
   input  logic [7:0]        out_ready,
   output logic [1:0]        occupancy
);

   logic [DATA_W-1:0] data_q [2];
   logic [2:0]        sel_q  [2];
   logic              wrPtr_q, wrPtr_d;
   logic              rdPtr_q, rdPtr_d;
   logic [1:0]        occ_q, occ_d;
   logic              live_q;
   logic              push, pop;
   logic [2:0]        headSel;

   // live_q holds in_ready low through reset and releases it on the first edge after.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         live_q  <= 1'b0;
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         occ_q   <= 2'd0;
      end else begin
         live_q  <= 1'b1;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         occ_q   <= occ_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push) begin
         data_q[wrPtr_q] <= in_data;
         sel_q[wrPtr_q]  <= in_sel;
      end
   end

   always_comb begin
      headSel = sel_q[rdPtr_q];
      push    = in_valid && in_ready;
      pop     = (occ_q != 2'd0) && out_ready[headSel];
      wrPtr_d = push ? ~wrPtr_q : wrPtr_q;
      rdPtr_d = pop ? ~rdPtr_q : rdPtr_q;
      occ_d   = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (pop && !push) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_comb begin
      in_ready  = live_q && (occ_q != 2'd2);
      occupancy = occ_q;
      out_valid = 8'h00;
      out_data  = '0;
      if (occ_q != 2'd0) begin
         out_valid = 8'h01 << headSel;
         out_data  = data_q[rdPtr_q];
      end
   end

endmodule

// File: tb/tb_dispatch1_8.sv
// Directed bench for dispatch1_8: accepted pushes feed a scoreboard queue that a
// negedge monitor drains on every completed output transfer.
module tb_dispatch1_8;

   logic        ACLK;
   logic        ARESETn;
   logic [31:0] in_data;
   logic [2:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [1:0]  occupancy;

   logic [39:0] sbQ [$];
   int          totalCount = 0;
   int          badCount   = 0;

   dispatch1_8 #(.DATA_W(32)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [2:0] s,
                                input logic [7:0] r);
      in_valid  = v;
      in_data   = d;
      in_sel    = s;
      out_ready = r;
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic settle();
      @(negedge ACLK);
   endtask

   // Monitor compares completed transfers first, then records this cycle's accepted push.
   always @(negedge ACLK) begin
      if (ARESETn) begin
         if (|(out_valid & out_ready)) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpectedTransfer", {24'h0, out_valid, out_data}, 64'h0);
            end else begin
               checkOutput("transfer", {24'h0, out_valid, out_data}, {24'h0, sbQ.pop_front()});
            end
         end
         if (in_valid && in_ready) begin
            sbQ.push_back({8'h01 << in_sel, in_data});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ARESETn = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h00);
      #3;
      checkOutput("rstInReady", in_ready, 0);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstOcc", occupancy, 0);
      checkOutput("rstOutData", out_data, 0);
      #9;
      ARESETn = 1'b1;
      #1;
      checkOutput("preEdgeInReady", in_ready, 0);
      tick();
      checkOutput("postEdgeInReady", in_ready, 1);

      // single entry
      applyStimulus(1'b1, 32'hDEADBEEF, 3'd5, 8'hFF);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'hFF);
      settle();
      checkOutput("singleValid", out_valid, 8'h20);
      checkOutput("singleData", out_data, 32'hDEADBEEF);
      checkOutput("singleOcc", occupancy, 1);
      tick();
      settle();
      checkOutput("singleDoneValid", out_valid, 0);
      checkOutput("singleDoneOcc", occupancy, 0);
      tick();

      // fill and stall
      applyStimulus(1'b1, 32'h11, 3'd0, 8'h00);
      tick();
      applyStimulus(1'b1, 32'h22, 3'd7, 8'h00);
      tick();
      applyStimulus(1'b1, 32'h33, 3'd1, 8'h00);
      settle();
      checkOutput("fullOcc", occupancy, 2);
      checkOutput("fullInReady", in_ready, 0);
      checkOutput("fullValid", out_valid, 8'h01);
      tick();
      settle();
      checkOutput("stallOcc", occupancy, 2);
      checkOutput("stallData", out_data, 32'h11);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h01);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h00);
      settle();
      checkOutput("afterPopOcc", occupancy, 1);
      checkOutput("afterPopInReady", in_ready, 1);
      checkOutput("afterPopValid", out_valid, 8'h80);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'hFF);
      tick();
      settle();
      checkOutput("drainOcc", occupancy, 0);
      tick();

      // wrong-channel ready never pops
      applyStimulus(1'b1, 32'h5A5A0033, 3'd3, 8'hF7);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'hF7);
      for (int i = 0; i < 4; i++) begin
         settle();
         checkOutput("wrongChValid", out_valid, 8'h08);
         checkOutput("wrongChData", out_data, 32'h5A5A0033);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h08);
      tick();
      settle();
      checkOutput("rightChOcc", occupancy, 0);
      tick();

      // streaming push/pop at occupancy 1
      applyStimulus(1'b1, 32'd0, 3'd0, 8'h00);
      tick();
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b1, i, i[2:0], 8'hFF);
         settle();
         checkOutput("streamValid", out_valid, 8'h01 << (i - 1));
         checkOutput("streamOcc", occupancy, 1);
         checkOutput("streamInReady", in_ready, 1);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 3'd0, 8'hFF);
      settle();
      checkOutput("streamLastValid", out_valid, 8'h80);
      checkOutput("streamLastData", out_data, 32'd7);
      tick();
      settle();
      checkOutput("streamDoneOcc", occupancy, 0);
      tick();

      // ordering across channels
      applyStimulus(1'b1, 32'hAAAA, 3'd2, 8'h00);
      tick();
      applyStimulus(1'b1, 32'hBBBB, 3'd6, 8'h00);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h40);
      settle();
      checkOutput("orderBlockValid", out_valid, 8'h04);
      tick();
      settle();
      checkOutput("orderBlockOcc", occupancy, 2);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h44);
      tick();
      settle();
      checkOutput("orderSecondValid", out_valid, 8'h40);
      checkOutput("orderSecondData", out_data, 32'hBBBB);
      checkOutput("orderSecondOcc", occupancy, 1);
      tick();
      settle();
      checkOutput("orderDoneOcc", occupancy, 0);
      tick();

      // reset mid-flight
      applyStimulus(1'b1, 32'h1111, 3'd1, 8'h00);
      tick();
      applyStimulus(1'b1, 32'h2222, 3'd2, 8'h00);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'h00);
      checkOutput("preRstOcc", occupancy, 2);
      ARESETn = 1'b0;
      #1;
      checkOutput("midRstValid", out_valid, 0);
      checkOutput("midRstOcc", occupancy, 0);
      checkOutput("midRstData", out_data, 0);
      checkOutput("midRstInReady", in_ready, 0);
      sbQ.delete();
      #2;
      ARESETn = 1'b1;
      tick();
      checkOutput("relInReady", in_ready, 1);
      applyStimulus(1'b1, 32'hCAFE, 3'd4, 8'hFF);
      tick();
      applyStimulus(1'b0, 32'h0, 3'd0, 8'hFF);
      settle();
      checkOutput("postRstValid", out_valid, 8'h10);
      checkOutput("postRstData", out_data, 32'hCAFE);
      tick();
      settle();
      checkOutput("postRstOcc", occupancy, 0);
      checkOutput("sbEmpty", sbQ.size(), 0);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
